// File: rtl/pass_arb_pkg.sv
// Shared types, constants and round-robin pick function for pass_arbiter.
package pass_arb_pkg;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam int unsigned CntW   = 16;
  localparam int unsigned MaxReq = 32;
  localparam int unsigned IdxW   = 5;

  typedef struct packed {
    logic            found;
    logic [IdxW-1:0] idx;
  } pick_t;

  // First set bit of valid scanning ptr, ptr+1, ... modulo nreq; ptr must be < nreq.
  function automatic pick_t rr_pick(input logic [MaxReq-1:0] valid,
                                    input logic [IdxW-1:0]   ptr,
                                    input int unsigned       nreq);
    pick_t       r;
    int unsigned k;
    r = '0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (i < nreq && !r.found) begin
        k = 32'(ptr) + i;
        if (k >= nreq) k = k - nreq;
        if (valid[k[IdxW-1:0]]) begin
          r.found = 1'b1;
          r.idx   = k[IdxW-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pass_arbiter_rr_grant.sv
// Combinational rotating priority encoder: req_valid + ptr -> one-hot grant and index.
module pass_arbiter_rr_grant
  import pass_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  pick_t             pick;
  logic [MaxReq-1:0] grant_full;
  logic              unused_pick;

  always_comb begin
    pick       = rr_pick(MaxReq'(req_valid), IdxW'(ptr), NREQ);
    found      = pick.found;
    idx        = pick.idx[IDW-1:0];
    grant_full = pick.found ? (MaxReq'(1) << pick.idx) : '0;
    grant      = grant_full[NREQ-1:0];
  end

  // Upper index/grant bits are always zero for NREQ < MaxReq.
  assign unused_pick = ^{pick.idx, grant_full};

endmodule

// File: rtl/pass_identity.sv
// Identity (pass-through) stage of the entropy-model datapath.
module pass_identity #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  assign out_data = in_data;

endmodule

// File: rtl/pass_arbiter.sv
// Round-robin arbiter feeding the shared identity stage into a one-entry output register.
// Optional per-requester 16-bit saturating grant counters when PASS_ARB_STATS_EN is defined.
module pass_arbiter
  import pass_arb_pkg::*;
#(
  parameter int unsigned  WIDTH = 8,
  parameter int unsigned  NREQ  = 4,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
`ifdef PASS_ARB_STATS_EN
  output logic [NREQ*CntW-1:0]  beat_cnt,
`endif
  output logic [IDW-1:0]        out_id
);

  logic [0:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gidx;
  logic             found;
  logic             accept;
  logic             take;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] id_data;

  pass_arbiter_rr_grant #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_grant (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .idx       (gidx),
    .found     (found)
  );

  assign sel_data = req_data[gidx*WIDTH +: WIDTH];

  pass_identity #(
    .WIDTH (WIDTH)
  ) u_identity (
    .in_data  (sel_data),
    .out_data (id_data)
  );

  assign accept    = (state_q == ST_EMPTY) | out_ready;
  assign take      = accept & found;
  assign req_ready = accept ? grant : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    if (accept) begin
      state_d = found ? ST_FULL : ST_EMPTY;
    end
    if (take) begin
      data_d = id_data;
      id_d   = gidx;
      ptr_d  = (32'(gidx) == NREQ - 1) ? '0 : gidx + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;

`ifdef PASS_ARB_STATS_EN
  logic [CntW-1:0] cnt_q [NREQ];
  logic [CntW-1:0] cnt_d [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (take && grant[i] && cnt_q[i] != '1) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) beat_cnt[i*CntW +: CntW] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_pass_arbiter.sv
// Scoreboard bench for pass_arbiter: stimulus pushes expected beats, a monitor pops on transfer.
module tb_pass_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
`ifdef PASS_ARB_STATS_EN
  logic [NREQ*16-1:0]    beat_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [IDW+WIDTH-1:0] sb[$];

  pass_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef PASS_ARB_STATS_EN
    .beat_cnt  (beat_cnt),
`endif
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle; check req_ready mid-cycle and queue the expected output beat.
  task automatic step(input logic [3:0] v, input logic ordy, input logic [3:0] exp_rdy,
                      input int exp_id, input string nm);
    logic [IDW-1:0] eid;
    req_valid = v;
    out_ready = ordy;
    @(negedge clk);
    chk(nm, 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      eid = IDW'(exp_id);
      sb.push_back({eid, req_data[exp_id*WIDTH +: WIDTH]});
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", {22'd0, out_id, out_data}, 32'hFFFF_FFFF);
      end else begin
        chk("out_beat", {22'd0, out_id, out_data}, {22'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'($urandom);
    req_data  = 32'($urandom);
    out_ready = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    out_ready = 1'b0;
    rst_n     = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_id", 32'(out_id), 32'd0);
      chk("idle_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;

    // Single requester 2: ptr 0 -> 3
    req_data = {8'h13, 8'hA5, 8'h11, 8'h10};
    step(4'b0100, 1'b1, 4'b0100, 2, "single_grant");
    chk("single_out", {22'd0, out_id, out_data}, {22'd0, 2'd2, 8'hA5});
    step(4'b0000, 1'b1, 4'b0000, 0, "single_drain");
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};

    // All valid from ptr 3: 3,0,1,2,3,0 -> ptr 1
    step(4'b1111, 1'b1, 4'b1000, 3, "rr_g3");
    step(4'b1111, 1'b1, 4'b0001, 0, "rr_g0");
    step(4'b1111, 1'b1, 4'b0010, 1, "rr_g1");
    step(4'b1111, 1'b1, 4'b0100, 2, "rr_g2");
    step(4'b1111, 1'b1, 4'b1000, 3, "rr_g3b");
    step(4'b1111, 1'b1, 4'b0001, 0, "rr_g0b");

    // Backpressure holds beat id0/0x10; next grant at ptr 1
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0, 4'b0000, 0, "bp_noready");
      chk("bp_hold", {22'd0, out_id, out_data}, {22'd0, 2'd0, 8'h10});
    end
    step(4'b1111, 1'b1, 4'b0010, 1, "bp_resume");

    // Wrap and skip: ptr 2 -> grant 2 sets ptr 3, then 0,1,0
    step(4'b0100, 1'b1, 4'b0100, 2, "ws_set");
    step(4'b0011, 1'b1, 4'b0001, 0, "ws_wrap0");
    step(4'b0011, 1'b1, 4'b0010, 1, "ws_g1");
    step(4'b0011, 1'b1, 4'b0001, 0, "ws_g0");
    step(4'b0000, 1'b1, 4'b0000, 0, "ws_drain");

    // Requester drops valid while blocked: nothing duplicated
    step(4'b0001, 1'b1, 4'b0001, 0, "drop_g0");
    step(4'b0010, 1'b0, 4'b0000, 0, "drop_blocked");
    step(4'b0000, 1'b0, 4'b0000, 0, "drop_gone");
    step(4'b0000, 1'b1, 4'b0000, 0, "drop_drain");
    step(4'b0000, 1'b1, 4'b0000, 0, "drop_idle");
    chk("drop_empty", 32'(out_valid), 32'd0);

    // Mid-transfer asynchronous reset discards the held beat
    step(4'b1000, 1'b1, 4'b1000, 3, "mr_g3");
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_out", {22'd0, out_id, out_data}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b1111, 1'b1, 4'b0001, 0, "mr_ptr0");
    step(4'b0000, 1'b1, 4'b0000, 0, "mr_drain");

`ifdef PASS_ARB_STATS_EN
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b1, 4'b0010, 1, "st_g1");
    step(4'b0000, 1'b1, 4'b0000, 0, "st_drain");
    chk("st_cnt1", 32'(beat_cnt[31:16]), 32'd3);
    chk("st_cnt0", 32'(beat_cnt[15:0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("st_rst_cnt", beat_cnt[31:0], 32'd0);
    chk("st_rst_valid", 32'(out_valid), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b1111, 1'b1, 4'b0001, 0, "st_ptr0");
    for (int i = 0; i < 65536; i++) step(4'b0010, 1'b1, 4'b0010, 1, "st_sat_g1");
    step(4'b0000, 1'b1, 4'b0000, 0, "st_sat_drain");
    chk("st_sat", 32'(beat_cnt[31:16]), 32'h0000_FFFF);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
